// File: rtl/register_scoreboard.sv
// Per-register in-flight write counters for the register stage.
// Stalls issue on RAW hazards, destination counter saturation or downstream backpressure.
module register_scoreboard #(
    parameter int NUM_REGS   = 8,
    parameter int REG_IDX_W  = 3,
    parameter int NUM_SRC    = 4,
    parameter int NUM_WB     = 2,
    parameter int CNT_W      = 2,
    parameter int BYTE_ALIAS = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_valid,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*REG_IDX_W-1:0]   src_reg,
    input  logic [NUM_SRC*2-1:0]           src_size,
    input  logic                           dst_valid,
    input  logic [REG_IDX_W-1:0]           dst_reg,
    input  logic [1:0]                     dst_size,
    input  logic                           next_stage_ready,
    input  logic [NUM_WB-1:0]              wb_enable,
    input  logic [NUM_WB*REG_IDX_W-1:0]    wb_reg,
    input  logic [NUM_WB*2-1:0]            wb_size,
    input  logic                           flush,
    output logic                           is_stall,
    output logic                           issue_fire,
    output logic [NUM_REGS-1:0]            pending_vec,
    output logic                           wb_underflow
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0]     cnt      [NUM_REGS];
    logic [CNT_W-1:0]     cnt_next [NUM_REGS];
    logic [REG_IDX_W-1:0] src_phys [NUM_SRC];
    logic [REG_IDX_W-1:0] wb_phys  [NUM_WB];
    logic [REG_IDX_W-1:0] dst_phys;
    logic                 hazard;
    logic                 sat;
    logic                 underflow_any;

    // 8-bit high-byte names (AH/CH/DH/BH) live in the low four registers.
    function automatic logic [REG_IDX_W-1:0] map_idx(input logic [REG_IDX_W-1:0] idx,
                                                     input logic [1:0]           size);
        if (BYTE_ALIAS != 0 && size == 2'd0 && 32'(idx) >= 32'd4)
            return REG_IDX_W'(32'(idx) - 32'd4);
        return idx;
    endfunction

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_phys[i] = map_idx(src_reg[i*REG_IDX_W +: REG_IDX_W], src_size[i*2 +: 2]);
            if (src_valid[i] && cnt[src_phys[i]] != '0)
                hazard = 1'b1;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_WB; p++)
            wb_phys[p] = map_idx(wb_reg[p*REG_IDX_W +: REG_IDX_W], wb_size[p*2 +: 2]);
    end

    assign dst_phys   = map_idx(dst_reg, dst_size);
    assign sat        = issue_valid & dst_valid & (cnt[dst_phys] == CNT_W'(CNT_MAX));
    assign is_stall   = issue_valid & (hazard | sat | ~next_stage_ready);
    assign issue_fire = issue_valid & ~is_stall;

    // Two guard bits: the sign bit catches underflow; the other absorbs a
    // (saturation-blocked) increment past the maximum.
    always_comb begin
        logic [CNT_W+1:0] sum;
        underflow_any = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            sum = {2'b00, cnt[r]};
            if (issue_fire && dst_valid && dst_phys == REG_IDX_W'(r))
                sum = sum + (CNT_W+2)'(1);
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_enable[p] && wb_phys[p] == REG_IDX_W'(r))
                    sum = sum - (CNT_W+2)'(1);
            end
            if (sum[CNT_W+1]) begin
                cnt_next[r]   = '0;
                underflow_any = 1'b1;
            end else if (sum[CNT_W]) begin
                cnt_next[r]   = CNT_W'(CNT_MAX);
            end else begin
                cnt_next[r]   = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
            wb_underflow <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
            wb_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= cnt_next[r];
            if (underflow_any)
                wb_underflow <= 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            pending_vec[r] = (cnt[r] != '0);
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed and random checks of register_scoreboard against a counter-array reference model.
module tb_register_scoreboard;

    localparam int NR = 8;
    localparam int W  = 3;
    localparam int NS = 4;
    localparam int NW = 2;
    localparam int CW = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              issue_valid;
    logic [NS-1:0]     src_valid;
    logic [NS*W-1:0]   src_reg;
    logic [NS*2-1:0]   src_size;
    logic              dst_valid;
    logic [W-1:0]      dst_reg;
    logic [1:0]        dst_size;
    logic              next_stage_ready;
    logic [NW-1:0]     wb_enable;
    logic [NW*W-1:0]   wb_reg;
    logic [NW*2-1:0]   wb_size;
    logic              flush;
    logic              is_stall;
    logic              issue_fire;
    logic [NR-1:0]     pending_vec;
    logic              wb_underflow;

    int m_cnt [NR];
    bit m_uf;
    int n_tests = 0;
    int n_fail  = 0;

    register_scoreboard #(
        .NUM_REGS(NR), .REG_IDX_W(W), .NUM_SRC(NS), .NUM_WB(NW), .CNT_W(CW), .BYTE_ALIAS(1)
    ) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .src_valid(src_valid), .src_reg(src_reg), .src_size(src_size),
        .dst_valid(dst_valid), .dst_reg(dst_reg), .dst_size(dst_size),
        .next_stage_ready(next_stage_ready),
        .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_size(wb_size),
        .flush(flush), .is_stall(is_stall), .issue_fire(issue_fire),
        .pending_vec(pending_vec), .wb_underflow(wb_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int phys(input int idx, input int size);
        if (size == 0 && idx >= 4) return idx - 4;
        return idx;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_uf = 1'b0;
    endtask

    task automatic idle();
        issue_valid = 1'b0; src_valid = '0; src_reg = '0; src_size = '1;
        dst_valid = 1'b0; dst_reg = '0; dst_size = 2'd3; next_stage_ready = 1'b1;
        wb_enable = '0; wb_reg = '0; wb_size = '1; flush = 1'b0;
    endtask

    task automatic set_src(input int i, input int r, input int s);
        src_valid[i] = 1'b1; src_reg[i*W +: W] = W'(r); src_size[i*2 +: 2] = 2'(s);
    endtask

    task automatic set_dst(input int r, input int s);
        issue_valid = 1'b1; dst_valid = 1'b1; dst_reg = W'(r); dst_size = 2'(s);
    endtask

    task automatic set_wb(input int p, input int r, input int s);
        wb_enable[p] = 1'b1; wb_reg[p*W +: W] = W'(r); wb_size[p*2 +: 2] = 2'(s);
    endtask

    // Check outputs against the model, clock once, then advance the model.
    task automatic step(input string tag);
        bit haz, sat, e_stall, e_fire;
        logic [NR-1:0] e_pend;
        int nv;
        #1;
        haz = 1'b0;
        for (int i = 0; i < NS; i++)
            if (src_valid[i] && m_cnt[phys(int'(src_reg[i*W +: W]), int'(src_size[i*2 +: 2]))] != 0)
                haz = 1'b1;
        sat = dst_valid && m_cnt[phys(int'(dst_reg), int'(dst_size))] == MAXC;
        e_stall = issue_valid && (haz || sat || !next_stage_ready);
        e_fire  = issue_valid && !e_stall;
        for (int r = 0; r < NR; r++) e_pend[r] = (m_cnt[r] != 0);
        chk($sformatf("%s.stall", tag), 32'(is_stall), 32'(e_stall));
        chk($sformatf("%s.fire", tag), 32'(issue_fire), 32'(e_fire));
        chk($sformatf("%s.pend", tag), 32'(pending_vec), 32'(e_pend));
        chk($sformatf("%s.uf", tag), 32'(wb_underflow), 32'(m_uf));
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else begin
            for (int r = 0; r < NR; r++) begin
                nv = m_cnt[r];
                if (e_fire && dst_valid && phys(int'(dst_reg), int'(dst_size)) == r) nv++;
                for (int p = 0; p < NW; p++)
                    if (wb_enable[p] && phys(int'(wb_reg[p*W +: W]), int'(wb_size[p*2 +: 2])) == r) nv--;
                if (nv < 0) begin nv = 0; m_uf = 1'b1; end
                m_cnt[r] = nv;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_clear();
        #3;
        chk("rst.pend", 32'(pending_vec), 32'h0);
        chk("rst.uf", 32'(wb_underflow), 32'h0);
        chk("rst.stall_idle", 32'(is_stall), 32'h0);
        issue_valid = 1'b1;
        #1;
        chk("rst.fire", 32'(issue_fire), 32'h1);
        chk("rst.stall", 32'(is_stall), 32'h0);
        idle();
        @(negedge clk);
        reset = 1'b0;

        // RAW on EAX, released the cycle after its writeback
        idle(); set_dst(0, 3); step("t1_issue");
        chk("t1.pend01", 32'(pending_vec), 32'h01);
        idle(); issue_valid = 1'b1; set_src(0, 0, 3); step("t1_raw");
        set_wb(0, 0, 3); step("t1_wb_same");
        wb_enable = '0; step("t1_after");
        chk("t1.pend00", 32'(pending_vec), 32'h00);

        // AH aliases EAX; ESP does not
        idle(); set_dst(4, 0); step("t2_ah");
        chk("t2.pend01", 32'(pending_vec), 32'h01);
        idle(); issue_valid = 1'b1; set_src(1, 0, 3); step("t2_eax");
        idle(); issue_valid = 1'b1; set_src(1, 4, 3); step("t2_esp");
        idle(); set_wb(0, 4, 0); step("t2_wb");

        // ECX saturation
        for (int k = 0; k < 3; k++) begin
            idle(); set_dst(1, 3); step("t3_fill");
        end
        chk("t3.pend02", 32'(pending_vec), 32'h02);
        idle(); set_dst(1, 3); step("t3_sat");
        set_wb(1, 1, 3); step("t3_sat_wb");
        wb_enable = '0; step("t3_release");
        idle(); set_wb(0, 1, 3); set_wb(1, 1, 3); step("t3_drain2");
        idle(); set_wb(0, 1, 3); step("t3_drain1");
        chk("t3.pend00", 32'(pending_vec), 32'h00);

        // dual writeback to EDX, then underflow
        idle(); set_dst(2, 3); step("t4_a");
        idle(); set_dst(2, 3); step("t4_b");
        idle(); set_wb(0, 2, 3); set_wb(1, 2, 3); step("t4_dual");
        chk("t4.pend00", 32'(pending_vec), 32'h00);
        chk("t4.uf0", 32'(wb_underflow), 32'h0);
        idle(); set_wb(0, 2, 3); step("t4_under");
        chk("t4.uf1", 32'(wb_underflow), 32'h1);
        idle(); step("t4_sticky");
        chk("t4.uf_sticky", 32'(wb_underflow), 32'h1);

        // EBX inc/dec net-out, then backpressure
        idle(); set_dst(3, 3); step("t5_a");
        idle(); set_dst(3, 3); set_wb(0, 3, 3); step("t5_net");
        chk("t5.pend08", 32'(pending_vec), 32'h08);
        idle(); set_dst(5, 3); next_stage_ready = 1'b0; step("t5_bp");
        chk("t5.pend08b", 32'(pending_vec), 32'h08);

        // flush with a firing issue
        idle(); set_dst(6, 3); step("t6_a");
        idle(); set_dst(7, 3); flush = 1'b1; step("t6_flush");
        chk("t6.pend00", 32'(pending_vec), 32'h00);
        chk("t6.uf0", 32'(wb_underflow), 32'h0);

        // async reset between edges
        idle(); set_dst(0, 3); step("t7_a");
        idle(); set_dst(1, 3); step("t7_b");
        idle(); set_wb(0, 5, 3); step("t7_uf");
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("t7.async_pend", 32'(pending_vec), 32'h00);
        chk("t7.async_uf", 32'(wb_underflow), 32'h0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;

        // random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            issue_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 3) == 0) set_src(i, $urandom_range(0, 7), $urandom_range(0, 3));
            dst_valid = ($urandom_range(0, 1) == 1);
            dst_reg   = W'($urandom_range(0, 7));
            dst_size  = 2'($urandom_range(0, 3));
            next_stage_ready = ($urandom_range(0, 4) != 0);
            for (int p = 0; p < NW; p++)
                if ($urandom_range(0, 3) == 0) set_wb(p, $urandom_range(0, 7), $urandom_range(0, 3));
            flush = ($urandom_range(0, 49) == 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
- Parametrised successor to the register-access stall logic in the register stage; tracks in-flight writes per architectural GPR.
- Keeps a counter per register instead of a single pending bit, so several writes to one register can be outstanding.
- Checks N source operands and multiple writeback ports, and handles x86 8-bit high-byte aliasing (AH/CH/DH/BH).
- Stalls issue on RAW hazards, destination-counter saturation, or downstream backpressure.

Parameters:
NUM_REGS, 8, number of tracked architectural registers
REG_IDX_W, 3, register index width (clog2 NUM_REGS)
NUM_SRC, 4, source operand checks per issue (op0, op1, SIB base, SIB index)
NUM_WB, 2, writeback ports
CNT_W, 2, per-register counter width; max outstanding writes = 2^CNT_W-1
BYTE_ALIAS, 1, 1 = size-0 indices 4..7 map to registers 0..3

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
issue_valid  input  1  instruction present in register stage
src_valid  input  NUM_SRC  per-source read enable
src_reg  input  NUM_SRC*REG_IDX_W  source indices, source i at [i*REG_IDX_W +: REG_IDX_W]
src_size  input  NUM_SRC*2  source sizes (0=8b, 1=16b, 3=32b)
dst_valid  input  1  instruction writes a register
dst_reg  input  REG_IDX_W  destination index
dst_size  input  2  destination size
next_stage_ready  input  1  downstream can accept
wb_enable  input  NUM_WB  per-port writeback retire
wb_reg  input  NUM_WB*REG_IDX_W  writeback indices
wb_size  input  NUM_WB*2  writeback sizes
flush  input  1  pipeline flush; clear all pending state
is_stall  output  1  hold register stage this cycle
issue_fire  output  1  instruction accepted this cycle
pending_vec  output  NUM_REGS  bit r = counter r nonzero
wb_underflow  output  1  sticky error: writeback to a register with a zero counter

Behaviour:
- Index mapping, applied to src, dst and wb identically: phys = (BYTE_ALIAS && size==0 && idx>=4) ? idx-4 : idx. Sizes 1 and 3 never alias. Size 2 is treated as size 3.
- hazard = issue_valid & (any i: src_valid[i] & cnt[phys_src_i]!=0).
- sat = issue_valid & dst_valid & cnt[phys_dst]==2^CNT_W-1.
- is_stall = issue_valid & (hazard | sat | !next_stage_ready).
- issue_fire = issue_valid & !is_stall.
- All three outputs are combinational from the registered counters.
- No same-cycle writeback bypass: a writeback clears a hazard visible from the next cycle.
- Counter update each cycle, per register r:
  - inc = issue_fire & dst_valid & phys_dst==r.
  - dec = number of ports p with wb_enable[p] & phys_wb_p==r; may be 0..NUM_WB.
  - cnt_next = cnt + inc - dec, computed at CNT_W+2 bits.
  - If the result is < 0: cnt_next = 0 and wb_underflow is set.
- inc and dec on the same register in the same cycle net out; a counter at 1 with inc=1, dec=1 stays 1.
- An issuing instruction whose dst equals one of its own sources cannot reach the counter update: it stalls on its source if that source is pending, otherwise it increments normally.
- flush is synchronous and has highest priority:
  - all counters go to 0 and wb_underflow clears on the next edge;
  - issue_fire still follows the formula, but its increment is discarded.
- pending_vec is derived from the registered counters.
- Reset (asynchronous) sets all counters to 0 and wb_underflow to 0.
- Reset outputs: pending_vec=0, wb_underflow=0. is_stall and issue_fire follow their inputs combinationally with all counters at 0.
- Reset asserted mid-operation discards all in-flight tracking immediately.
- Latency: counter changes are visible on outputs one cycle after the triggering edge.

Test Plan:
- Reset then issue dst=EAX(0, size 3) with ready=1 -> issue_fire=1; next cycle pending_vec=8'h01. Next instruction with src0=EAX -> is_stall=1. Then wb port0 reg 0 -> stall drops the cycle after the writeback.
- Issue dst=AH (reg 4, size 0) -> pending_vec bit 0 set, bit 4 clear. Source EAX stalls; source ESP (4, size 3) does not stall.
- Three back-to-back issues to dst=ECX (CNT_W=2) -> cnt=3; fourth issue to ECX stalls (sat) with no sources pending; one wb to ECX releases it the next cycle.
- cnt[EDX]=2; both wb ports target EDX in the same cycle -> cnt=0, pending bit 2 clears, wb_underflow stays 0. A further wb to EDX -> wb_underflow=1 and stays set.
- Same-cycle issue-increment and wb-decrement on EBX with cnt=1 -> cnt stays 1. Next-stage-ready=0 with no hazard -> is_stall=1, issue_fire=0, counters unchanged.
- Counters nonzero, flush=1 concurrent with a firing issue -> next cycle pending_vec=0, wb_underflow=0. Async reset asserted between edges -> outputs clear without waiting for a clock edge.
